// File: rtl/ahbl_splitter.sv
// AHB-Lite 1:N address decoder. Routes each address phase to the single slave
// whose (addr & mask) == base (lowest index wins on overlap), remembers the
// selection for the data phase, muxes the response back, and answers
// unmapped accesses with a built-in two-cycle ERROR response.

// Per-slave address match and address-phase fan-out.
module ahbl_splitter_port #(
    parameter int                W_ADDR = 32,
    parameter int                W_DATA = 32,
    parameter logic [W_ADDR-1:0] MAP    = '0,
    parameter logic [W_ADDR-1:0] MASK   = '0
) (
    input  logic [W_ADDR-1:0] haddr,
    input  logic              hwrite,
    input  logic [1:0]        htrans,
    input  logic [2:0]        hsize,
    input  logic [2:0]        hburst,
    input  logic [3:0]        hprot,
    input  logic              hmastlock,
    input  logic [W_DATA-1:0] hwdata,
    input  logic              hready,
    input  logic              sel,
    output logic              match,
    output logic [W_ADDR-1:0] m_haddr,
    output logic              m_hwrite,
    output logic [1:0]        m_htrans,
    output logic [2:0]        m_hsize,
    output logic [2:0]        m_hburst,
    output logic [3:0]        m_hprot,
    output logic              m_hmastlock,
    output logic [W_DATA-1:0] m_hwdata,
    output logic              m_hready
);

    assign match       = ((haddr & MASK) == MAP);
    // Only the selected slave ever sees an active transfer.
    assign m_htrans    = sel ? htrans : 2'b00;
    assign m_haddr     = haddr;
    assign m_hwrite    = hwrite;
    assign m_hsize     = hsize;
    assign m_hburst    = hburst;
    assign m_hprot     = hprot;
    assign m_hmastlock = hmastlock;
    assign m_hwdata    = hwdata;
    assign m_hready    = hready;

endmodule

module ahbl_splitter #(
    parameter int                        N_PORTS   = 2,
    parameter int                        W_ADDR    = 32,
    parameter int                        W_DATA    = 32,
    parameter logic [N_PORTS*W_ADDR-1:0] ADDR_MAP  = '0,
    parameter logic [N_PORTS*W_ADDR-1:0] ADDR_MASK = '0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    // upstream (slave port)
    input  logic                        ahbls_hready,
    output logic                        ahbls_hready_resp,
    output logic                        ahbls_hresp,
    input  logic [W_ADDR-1:0]           ahbls_haddr,
    input  logic                        ahbls_hwrite,
    input  logic [1:0]                  ahbls_htrans,
    input  logic [2:0]                  ahbls_hsize,
    input  logic [2:0]                  ahbls_hburst,
    input  logic [3:0]                  ahbls_hprot,
    input  logic                        ahbls_hmastlock,
    input  logic [W_DATA-1:0]           ahbls_hwdata,
    output logic [W_DATA-1:0]           ahbls_hrdata,
    // downstream (master ports)
    output logic [N_PORTS-1:0]          ahblm_hready,
    input  logic [N_PORTS-1:0]          ahblm_hready_resp,
    input  logic [N_PORTS-1:0]          ahblm_hresp,
    output logic [N_PORTS*W_ADDR-1:0]   ahblm_haddr,
    output logic [N_PORTS-1:0]          ahblm_hwrite,
    output logic [N_PORTS*2-1:0]        ahblm_htrans,
    output logic [N_PORTS*3-1:0]        ahblm_hsize,
    output logic [N_PORTS*3-1:0]        ahblm_hburst,
    output logic [N_PORTS*4-1:0]        ahblm_hprot,
    output logic [N_PORTS-1:0]          ahblm_hmastlock,
    output logic [N_PORTS*W_DATA-1:0]   ahblm_hwdata,
    input  logic [N_PORTS*W_DATA-1:0]   ahblm_hrdata
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ERR1 = 2'd1;
    localparam logic [1:0] ST_ERR2 = 2'd2;

    logic [N_PORTS-1:0] match;
    logic [N_PORTS-1:0] sel_a;
    logic [N_PORTS-1:0] sel_d_d, sel_d_q;
    logic [N_PORTS-1:0] resp_sel;
    logic               err_req_d, err_req_q;
    logic [1:0]         state_d, state_q;
    logic               active;
    logic               unmapped;
    logic               err_capture;

    for (genvar i = 0; i < N_PORTS; i++) begin : g_port
        ahbl_splitter_port #(
            .W_ADDR (W_ADDR),
            .W_DATA (W_DATA),
            .MAP    (ADDR_MAP[i*W_ADDR +: W_ADDR]),
            .MASK   (ADDR_MASK[i*W_ADDR +: W_ADDR])
        ) u_port (
            .haddr       (ahbls_haddr),
            .hwrite      (ahbls_hwrite),
            .htrans      (ahbls_htrans),
            .hsize       (ahbls_hsize),
            .hburst      (ahbls_hburst),
            .hprot       (ahbls_hprot),
            .hmastlock   (ahbls_hmastlock),
            .hwdata      (ahbls_hwdata),
            .hready      (ahbls_hready),
            .sel         (sel_a[i]),
            .match       (match[i]),
            .m_haddr     (ahblm_haddr[i*W_ADDR +: W_ADDR]),
            .m_hwrite    (ahblm_hwrite[i]),
            .m_htrans    (ahblm_htrans[i*2 +: 2]),
            .m_hsize     (ahblm_hsize[i*3 +: 3]),
            .m_hburst    (ahblm_hburst[i*3 +: 3]),
            .m_hprot     (ahblm_hprot[i*4 +: 4]),
            .m_hmastlock (ahblm_hmastlock[i]),
            .m_hwdata    (ahblm_hwdata[i*W_DATA +: W_DATA]),
            .m_hready    (ahblm_hready[i])
        );
    end

    // Priority select: scan high to low so the lowest matching index is kept.
    always_comb begin
        sel_a = '0;
        for (int i = N_PORTS - 1; i >= 0; i--) begin
            if (match[i]) begin
                sel_a    = '0;
                sel_a[i] = 1'b1;
            end
        end
    end

    assign active      = ahbls_htrans[1];
    assign unmapped    = (sel_a == '0);
    assign err_capture = ahbls_hready && active && unmapped;

    // Data-phase selection advances only when the address phase is accepted.
    always_comb begin
        sel_d_d   = sel_d_q;
        err_req_d = err_req_q;
        if (ahbls_hready) begin
            sel_d_d   = active ? sel_a : '0;
            err_req_d = active && unmapped;
        end
    end

    // Default-slave sequencing: ERR1 (wait, ERROR) then ERR2 (ready, ERROR).
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (err_capture) state_d = ST_ERR1;
            ST_ERR1: state_d = ST_ERR2;
            ST_ERR2: state_d = err_capture ? ST_ERR1 : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Data-phase state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_d_q   <= '0;
            err_req_q <= 1'b0;
            state_q   <= ST_IDLE;
        end else begin
            sel_d_q   <= sel_d_d;
            err_req_q <= err_req_d;
            state_q   <= state_d;
        end
    end

    // An error data phase never forwards any slave's response.
    assign resp_sel = err_req_q ? '0 : sel_d_q;

    // Response mux: owning slave, else default slave, else idle OKAY.
    always_comb begin
        ahbls_hready_resp = 1'b1;
        ahbls_hresp       = 1'b0;
        ahbls_hrdata      = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (resp_sel[i]) begin
                ahbls_hready_resp = ahblm_hready_resp[i];
                ahbls_hresp       = ahblm_hresp[i];
                ahbls_hrdata      = ahblm_hrdata[i*W_DATA +: W_DATA];
            end
        end
        case (state_q)
            ST_ERR1: begin
                ahbls_hready_resp = 1'b0;
                ahbls_hresp       = 1'b1;
                ahbls_hrdata      = '0;
            end
            ST_ERR2: begin
                ahbls_hready_resp = 1'b1;
                ahbls_hresp       = 1'b1;
                ahbls_hrdata      = '0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ahbl_splitter.sv
// Bench for ahbl_splitter: three slaves, directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// transaction-level model (who owns the current data phase).
module tb_ahbl_splitter;

    localparam int N = 3;
    localparam logic [31:0] BASE [3] = '{32'h0000_0000, 32'h1000_0000, 32'h2000_0000};
    localparam int OWN_NONE = -1;
    localparam int OWN_ERR1 = 10;
    localparam int OWN_ERR2 = 11;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // upstream master drive
    logic [31:0] u_haddr;
    logic        u_hwrite;
    logic [1:0]  u_htrans;
    logic [2:0]  u_hsize;
    logic [2:0]  u_hburst;
    logic [3:0]  u_hprot;
    logic        u_hmastlock;
    logic [31:0] u_hwdata;
    // slave responses
    logic [N-1:0]    s_rdy;
    logic [N-1:0]    s_rsp;
    logic [N*32-1:0] s_rdata;

    wire logic        hready_resp, hresp;
    wire logic [31:0] hrdata;
    wire logic        up_hready;
    wire logic [N-1:0]    m_hready, m_hwrite, m_hmastlock;
    wire logic [N*32-1:0] m_haddr, m_hwdata;
    wire logic [N*2-1:0]  m_htrans;
    wire logic [N*3-1:0]  m_hsize, m_hburst;
    wire logic [N*4-1:0]  m_hprot;
    wire logic        o_hready_resp, o_hresp;
    wire logic [31:0] o_hrdata;
    wire logic [N-1:0]    o_hready, o_hwrite, o_hmastlock;
    wire logic [N*32-1:0] o_haddr, o_hwdata;
    wire logic [N*2-1:0]  o_htrans;
    wire logic [N*3-1:0]  o_hsize, o_hburst;
    wire logic [N*4-1:0]  o_hprot;

    // Single upstream master: bus HREADY is the splitter's own response.
    assign up_hready = hready_resp;

    ahbl_splitter #(
        .N_PORTS(N), .W_ADDR(32), .W_DATA(32),
        .ADDR_MAP ({32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
        .ADDR_MASK({32'hF000_0000, 32'hF000_0000, 32'hF000_0000})
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ahbls_hready(up_hready), .ahbls_hready_resp(hready_resp), .ahbls_hresp(hresp),
        .ahbls_haddr(u_haddr), .ahbls_hwrite(u_hwrite), .ahbls_htrans(u_htrans),
        .ahbls_hsize(u_hsize), .ahbls_hburst(u_hburst), .ahbls_hprot(u_hprot),
        .ahbls_hmastlock(u_hmastlock), .ahbls_hwdata(u_hwdata), .ahbls_hrdata(hrdata),
        .ahblm_hready(m_hready), .ahblm_hready_resp(s_rdy), .ahblm_hresp(s_rsp),
        .ahblm_haddr(m_haddr), .ahblm_hwrite(m_hwrite), .ahblm_htrans(m_htrans),
        .ahblm_hsize(m_hsize), .ahblm_hburst(m_hburst), .ahblm_hprot(m_hprot),
        .ahblm_hmastlock(m_hmastlock), .ahblm_hwdata(m_hwdata), .ahblm_hrdata(s_rdata)
    );

    // Second instance with slave 0's mask widened so it overlaps slave 1.
    ahbl_splitter #(
        .N_PORTS(N), .W_ADDR(32), .W_DATA(32),
        .ADDR_MAP ({32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
        .ADDR_MASK({32'hF000_0000, 32'hF000_0000, 32'hE000_0000})
    ) dut_ov (
        .clk(clk), .rst_n(rst_n),
        .ahbls_hready(up_hready), .ahbls_hready_resp(o_hready_resp), .ahbls_hresp(o_hresp),
        .ahbls_haddr(u_haddr), .ahbls_hwrite(u_hwrite), .ahbls_htrans(u_htrans),
        .ahbls_hsize(u_hsize), .ahbls_hburst(u_hburst), .ahbls_hprot(u_hprot),
        .ahbls_hmastlock(u_hmastlock), .ahbls_hwdata(u_hwdata), .ahbls_hrdata(o_hrdata),
        .ahblm_hready(o_hready), .ahblm_hready_resp(s_rdy), .ahblm_hresp(s_rsp),
        .ahblm_haddr(o_haddr), .ahblm_hwrite(o_hwrite), .ahblm_htrans(o_htrans),
        .ahblm_hsize(o_hsize), .ahblm_hburst(o_hburst), .ahblm_hprot(o_hprot),
        .ahblm_hmastlock(o_hmastlock), .ahblm_hwdata(o_hwdata), .ahblm_hrdata(s_rdata)
    );

    int errors = 0;
    int checks = 0;

    // model state
    int   owner = OWN_NONE;
    logic exp_hready;
    logic cap_hready = 1'b1;
    logic cap_active = 1'b0;
    int   cap_dec = -1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Which slave an address belongs to under the map; -1 for unmapped.
    function automatic int decode(input logic [31:0] a, input bit ov);
        logic [31:0] mask;
        for (int i = 0; i < N; i++) begin
            mask = (ov && i == 0) ? 32'hE000_0000 : 32'hF000_0000;
            if ((a & mask) == BASE[i]) return i;
        end
        return -1;
    endfunction

    // Compare every output against the model; record what the edge will accept.
    task automatic model_check();
        int          d, dov;
        logic        e_rsp;
        logic [31:0] e_rdata;
        d   = decode(u_haddr, 1'b0);
        dov = decode(u_haddr, 1'b1);
        case (owner)
            OWN_ERR1: begin exp_hready = 1'b0; e_rsp = 1'b1; e_rdata = '0; end
            OWN_ERR2: begin exp_hready = 1'b1; e_rsp = 1'b1; e_rdata = '0; end
            OWN_NONE: begin exp_hready = 1'b1; e_rsp = 1'b0; e_rdata = '0; end
            default: begin
                exp_hready = s_rdy[owner];
                e_rsp      = s_rsp[owner];
                e_rdata    = s_rdata[owner*32 +: 32];
            end
        endcase
        chk("hready_resp", hready_resp, exp_hready);
        chk("hresp", hresp, e_rsp);
        if (owner != OWN_ERR1 && owner != OWN_ERR2) chk("hrdata", hrdata, e_rdata);
        for (int k = 0; k < N; k++) begin
            chk($sformatf("htrans%0d", k), m_htrans[k*2 +: 2], (d == k) ? u_htrans : 2'b00);
            chk($sformatf("ov_htrans%0d", k), o_htrans[k*2 +: 2], (dov == k) ? u_htrans : 2'b00);
            chk($sformatf("bcast%0d", k),
                {m_haddr[k*32 +: 32], m_hwrite[k], m_hsize[k*3 +: 3], m_hburst[k*3 +: 3],
                 m_hprot[k*4 +: 4], m_hmastlock[k], m_hready[k]},
                {u_haddr, u_hwrite, u_hsize, u_hburst, u_hprot, u_hmastlock, exp_hready});
            chk($sformatf("hwdata%0d", k), m_hwdata[k*32 +: 32], u_hwdata);
        end
        cap_hready = exp_hready;
        cap_active = u_htrans[1];
        cap_dec    = d;
    endtask

    task automatic at_neg();
        @(negedge clk);
        model_check();
    endtask

    // Advance the data-phase owner across the clock edge.
    task automatic at_pos();
        @(posedge clk);
        if (!rst_n)                owner = OWN_NONE;
        else if (owner == OWN_ERR1) owner = OWN_ERR2;
        else if (cap_hready)        owner = !cap_active ? OWN_NONE : (cap_dec >= 0 ? cap_dec : OWN_ERR1);
        else if (owner == OWN_ERR2) owner = OWN_NONE;
        #1;
    endtask

    task automatic step();
        at_neg();
        at_pos();
    endtask

    task automatic addr(input logic [31:0] a, input logic [1:0] t, input logic w);
        u_haddr  = a;
        u_htrans = t;
        u_hwrite = w;
    endtask

    initial begin
        rst_n = 1'b0;
        addr(32'h0, 2'b00, 1'b0);
        u_hsize = 3'd2; u_hburst = 3'd0; u_hprot = 4'h3; u_hmastlock = 1'b0;
        u_hwdata = '0;
        s_rdy = '1; s_rsp = '0; s_rdata = '0;

        // reset state
        step(); step();
        at_neg();
        chk("rst_hready_resp", hready_resp, 1'b1);
        chk("rst_hresp", hresp, 1'b0);
        chk("rst_hrdata", hrdata, 32'h0);
        chk("rst_htrans", m_htrans, 6'h00);
        at_pos();
        rst_n = 1'b1;
        step();

        // read slave 1 with one wait state
        addr(32'h1000_0040, 2'b10, 1'b0);
        at_neg(); chk("rd1_htrans", m_htrans, 6'h08); at_pos();
        addr(32'h0, 2'b00, 1'b0); s_rdy[1] = 1'b0;
        at_neg(); chk("rd1_wait", hready_resp, 1'b0); at_pos();
        s_rdy[1] = 1'b1; s_rdata[32 +: 32] = 32'hDEAD_BEEF;
        at_neg();
        chk("rd1_ready", hready_resp, 1'b1);
        chk("rd1_data", hrdata, 32'hDEAD_BEEF);
        chk("rd1_resp", hresp, 1'b0);
        at_pos();

        // write slave 0 then read slave 2 back to back
        addr(32'h0000_0010, 2'b10, 1'b1);
        at_neg(); chk("wr0_htrans", m_htrans, 6'h02); at_pos();
        addr(32'h2000_0000, 2'b10, 1'b0); u_hwdata = 32'hCAFE_F00D;
        at_neg();
        chk("rd2_htrans", m_htrans, 6'h20);
        chk("wr0_hwdata", m_hwdata[31:0], 32'hCAFE_F00D);
        at_pos();
        addr(32'h0, 2'b00, 1'b0);
        s_rdata[0 +: 32] = 32'hBAD0_BAD0; s_rdata[64 +: 32] = 32'h1234_5678;
        at_neg(); chk("rd2_data", hrdata, 32'h1234_5678); at_pos();

        // unmapped access, HTRANS dropped to IDLE during ERR1
        addr(32'h3000_0000, 2'b10, 1'b0);
        at_neg(); chk("err_htrans", m_htrans, 6'h00); at_pos();
        addr(32'h0, 2'b00, 1'b0);
        at_neg(); chk("err1", {hready_resp, hresp}, 2'b01); at_pos();
        at_neg(); chk("err2", {hready_resp, hresp}, 2'b11); at_pos();
        at_neg(); chk("err_done", {hready_resp, hresp}, 2'b10); at_pos();

        // two unmapped accesses, second presented during ERR2
        addr(32'h3000_0000, 2'b10, 1'b0);
        step();
        at_neg(); chk("b2b_err1a", {hready_resp, hresp}, 2'b01); at_pos();
        addr(32'h5000_0000, 2'b10, 1'b0);
        at_neg(); chk("b2b_err2a", {hready_resp, hresp}, 2'b11); at_pos();
        addr(32'h0, 2'b00, 1'b0);
        at_neg(); chk("b2b_err1b", {hready_resp, hresp}, 2'b01); at_pos();
        at_neg(); chk("b2b_err2b", {hready_resp, hresp}, 2'b11); at_pos();

        // overlapping masks: lowest index wins
        addr(32'h1000_0000, 2'b10, 1'b0);
        at_neg();
        chk("ov_sel0", o_htrans, 6'h02);
        chk("nov_sel1", m_htrans, 6'h08);
        at_pos();
        addr(32'h0, 2'b00, 1'b0);
        step();

        // reset asserted during ERR1
        addr(32'h3000_0000, 2'b10, 1'b0);
        step();
        addr(32'h0, 2'b00, 1'b0);
        at_neg(); chk("rst_err1", {hready_resp, hresp}, 2'b01);
        #2 rst_n = 1'b0; owner = OWN_NONE;
        #1 chk("rst_async", {hready_resp, hresp}, 2'b10);
        at_pos();
        rst_n = 1'b1;
        at_neg(); chk("rst_after", {hready_resp, hresp}, 2'b10); at_pos();

        // randomized traffic; master holds its address phase while stalled
        for (int n = 0; n < 600; n++) begin
            for (int k = 0; k < N; k++) begin
                s_rdy[k] = ($urandom_range(0, 3) != 0);
                s_rsp[k] = ($urandom_range(0, 9) == 0);
                s_rdata[k*32 +: 32] = $urandom;
            end
            if (cap_hready) begin
                u_haddr     = ($urandom & 32'h0FFF_FFFC) | (32'($urandom_range(0, 5)) << 28);
                u_htrans    = 2'($urandom_range(0, 3));
                u_hwrite    = 1'($urandom);
                u_hsize     = 3'($urandom);
                u_hburst    = 3'($urandom);
                u_hprot     = 4'($urandom);
                u_hmastlock = 1'($urandom);
                u_hwdata    = $urandom;
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
